// File: rtl/dmem_responder_if.sv
// Core-side data-memory bus between the single-cycle core and dmem_responder.
//   addr       byte address (core ALUResult)
//   writeData  store data, right-aligned
//   memWrite   store strobe
//   memType    access type, RISC-V funct3 encoding
//   readData   load data, extended to 64 bits (combinational)
//   storeFault sticky misaligned-store flag
// master = core side, slave = responder side.
interface dmem_responder_if;
  localparam int unsigned DATA_BUS_BITS     = 64;
  localparam int unsigned MEM_TYPE_BUS_BITS = 3;

  logic [DATA_BUS_BITS-1:0]     addr;
  logic [DATA_BUS_BITS-1:0]     writeData;
  logic                         memWrite;
  logic [MEM_TYPE_BUS_BITS-1:0] memType;
  logic [DATA_BUS_BITS-1:0]     readData;
  logic                         storeFault;

  modport master (
    output addr, writeData, memWrite, memType,
    input  readData, storeFault
  );

  modport slave (
    input  addr, writeData, memWrite, memType,
    output readData, storeFault
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressable 64-bit RAM plus an MMIO window
// with a console transmit FIFO, a status register and a cycle counter.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   bus (slave)     addr/writeData/memWrite/memType in, readData/storeFault out
//   txData, txValid console FIFO head byte and non-empty flag
//   txReady         sink accepts the head byte
// Optional feature: define DMEM_CONSOLE_EN to build the console FIFO and the
// CONSOLE/STATUS registers; otherwise they read 0 and the tx ports are idle.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned CONSOLE_DEPTH = 8,
  parameter logic [63:0] MMIO_BASE     = 64'h0000_0000_1000_0000
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus,
  output logic [7:0]       txData,
  output logic             txValid,
  input  logic             txReady
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned PTR_W = $clog2(CONSOLE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [63:0]      ram [DEPTH_WORDS];
  logic [63:0]      cycle_cnt;
  logic             store_fault;

  logic [2:0]       offset;
  logic [IDX_W-1:0] word_idx;
  logic             is_mmio;
  logic [63:0]      mmio_off;
  logic             sel_cycle;
  logic [7:0]       size_mask;
  logic [2:0]       align_mask;
  logic             misaligned;
  logic [7:0]       byte_en;
  logic             ram_we;
  logic             cycle_we;
  logic [63:0]      wr_shift;
  logic [63:0]      rd_word;
  logic [63:0]      rd_shift;
  logic [63:0]      rd_ext;

`ifdef DMEM_CONSOLE_EN
  logic [7:0]       fifo_mem [CONSOLE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             sel_console;
  logic             sel_status;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push_ok;
  logic             pop;
`endif

  // Address decode
  assign offset    = bus.addr[2:0];
  assign word_idx  = bus.addr[3 +: IDX_W];
  assign is_mmio   = bus.addr >= MMIO_BASE;
  assign mmio_off  = bus.addr - MMIO_BASE;
  assign sel_cycle = is_mmio && (mmio_off[63:3] == 61'd2);

  // Size mask and alignment requirement from memType[1:0]
  always_comb begin
    size_mask  = 8'hFF;
    align_mask = 3'b111;
    unique case (bus.memType[1:0])
      2'd0: begin size_mask = 8'h01; align_mask = 3'b000; end
      2'd1: begin size_mask = 8'h03; align_mask = 3'b001; end
      2'd2: begin size_mask = 8'h0F; align_mask = 3'b011; end
      default: begin size_mask = 8'hFF; align_mask = 3'b111; end
    endcase
  end

  assign misaligned = |(offset & align_mask);
  // Aligned stores never spill past byte 7, so truncation is safe.
  assign byte_en    = 8'(size_mask << offset);
  assign wr_shift   = bus.writeData << {offset, 3'b000};
  assign ram_we     = bus.memWrite && !is_mmio && !misaligned && !reset;
  assign cycle_we   = bus.memWrite && sel_cycle && (bus.memType[1:0] == 2'b11);

  // RAM byte-enable write; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (byte_en[b]) ram[word_idx][8*b +: 8] <= wr_shift[8*b +: 8];
      end
    end
  end

  // Sticky misaligned-store flag
  always_ff @(posedge clk) begin
    if (reset)                                     store_fault <= 1'b0;
    else if (bus.memWrite && !is_mmio && misaligned) store_fault <= 1'b1;
  end

  // Free-running cycle counter; a D-size write overrides the increment
  always_ff @(posedge clk) begin
    if (reset)         cycle_cnt <= '0;
    else if (cycle_we) cycle_cnt <= bus.writeData;
    else               cycle_cnt <= cycle_cnt + 64'd1;
  end

`ifdef DMEM_CONSOLE_EN
  assign sel_console = is_mmio && (mmio_off[63:3] == 61'd0);
  assign sel_status  = is_mmio && (mmio_off[63:3] == 61'd1);
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(CONSOLE_DEPTH));
  assign pop         = !fifo_empty && txReady;
  assign push_req    = bus.memWrite && sel_console;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok     = push_req && (!fifo_full || pop);

  // FIFO storage, no reset needed: only entries below count are visible
  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_mem[wr_ptr] <= bus.writeData[7:0];
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (bus.memWrite && sel_status)  overflow <= 1'b0;
      else if (push_req && !push_ok)   overflow <= 1'b1;
    end
  end

  assign txValid = !fifo_empty;
  assign txData  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
`else
  logic unused_tx_ready;
  assign unused_tx_ready = txReady;
  assign txValid = 1'b0;
  assign txData  = 8'h00;
`endif

  // Load word selection
  always_comb begin
    rd_word = '0;
    if (!is_mmio)       rd_word = ram[word_idx];
    else if (sel_cycle) rd_word = cycle_cnt;
`ifdef DMEM_CONSOLE_EN
    else if (sel_status) rd_word = {59'd0, overflow, fifo_full, fifo_empty, 2'b00};
`endif
  end

  assign rd_shift = rd_word >> {offset, 3'b000};

  // Truncate to access size, then sign- or zero-extend
  always_comb begin
    rd_ext = rd_shift;
    unique case (bus.memType[1:0])
      2'd0: rd_ext = bus.memType[2] ? {56'd0, rd_shift[7:0]}
                                    : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'd1: rd_ext = bus.memType[2] ? {48'd0, rd_shift[15:0]}
                                    : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2: rd_ext = bus.memType[2] ? {32'd0, rd_shift[31:0]}
                                    : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign bus.readData   = rd_ext;
  assign bus.storeFault = store_fault;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// randomized traffic compared against a byte-level behavioural model.
module tb_dmem_responder;
  localparam int unsigned DEPTH_WORDS   = 1024;
  localparam int unsigned CONSOLE_DEPTH = 8;
  localparam int unsigned RAM_BYTES     = DEPTH_WORDS * 8;
  localparam logic [63:0] MMIO_BASE     = 64'h0000_0000_1000_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;

  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS  (DEPTH_WORDS),
    .CONSOLE_DEPTH(CONSOLE_DEPTH),
    .MMIO_BASE    (MMIO_BASE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .txData (tx_data),
    .txValid(tx_valid),
    .txReady(tx_ready)
  );

  int tests  = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mb [RAM_BYTES];
  logic [63:0] m_cyc;
  logic        m_ovf;
  logic        m_fault;
  logic [7:0]  m_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_word(input logic [63:0] a);
    logic [63:0] w;
    logic [63:0] r;
    int unsigned base;
    w = '0;
    if (a < MMIO_BASE) begin
      base = 32'(a % 64'(RAM_BYTES));
      base = base - (base % 8);
      for (int i = 0; i < 8; i++) w[8*i +: 8] = mb[base + 32'(i)];
    end else begin
      r = (a - MMIO_BASE) / 8;
      if (r == 2) w = m_cyc;
`ifdef DMEM_CONSOLE_EN
      else if (r == 1) begin
        w[4] = m_ovf;
        w[3] = (m_q.size() == CONSOLE_DEPTH);
        w[2] = (m_q.size() == 0);
      end
`endif
    end
    return w;
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] w, input int off, input logic [2:0] mt);
    int n;
    logic [63:0] v;
    n = 1 << mt[1:0];
    v = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = w[8*(off+i) +: 8];
    if (!mt[2] && n < 8 && v[8*n-1])
      for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  task automatic model_update(input logic rst, input logic [63:0] a, input logic [63:0] wd,
                              input logic we, input logic [2:0] mt, input logic rdy);
    int n;
    int unsigned ia;
    logic [63:0] r;
    logic pop;
    if (rst) begin
      m_cyc = '0; m_ovf = 1'b0; m_fault = 1'b0; m_q.delete();
      return;
    end
    n = 1 << mt[1:0];
    pop = 1'b0;
`ifdef DMEM_CONSOLE_EN
    pop = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
`endif
    if (we && a < MMIO_BASE) begin
      if (int'(a[2:0]) % n != 0) m_fault = 1'b1;
      else begin
        ia = 32'(a % 64'(RAM_BYTES));
        for (int i = 0; i < n; i++) mb[ia + 32'(i)] = wd[8*i +: 8];
      end
    end
    r = (a - MMIO_BASE) / 8;
    if (we && a >= MMIO_BASE && r == 2 && mt[1:0] == 2'b11) m_cyc = wd;
    else m_cyc = m_cyc + 64'd1;
`ifdef DMEM_CONSOLE_EN
    if (we && a >= MMIO_BASE && r == 0) begin
      if (m_q.size() < CONSOLE_DEPTH) m_q.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end
    if (we && a >= MMIO_BASE && r == 1) m_ovf = 1'b0;
`endif
  endtask

  // One clock cycle: drive, compare outputs against the model, advance model
  task automatic step(input logic rst, input logic [63:0] a, input logic [63:0] wd,
                      input logic we, input logic [2:0] mt, input logic rdy);
    logic [63:0] exp_tx;
    logic [63:0] exp_tv;
    @(negedge clk);
    reset = rst; bus.addr = a; bus.writeData = wd; bus.memWrite = we;
    bus.memType = mt; tx_ready = rdy;
    #1;
    exp_tx = '0;
    exp_tv = '0;
`ifdef DMEM_CONSOLE_EN
    if (m_q.size() > 0) begin exp_tx = 64'(m_q[0]); exp_tv = 64'd1; end
`endif
    check("readData", bus.readData, extract(model_word(a), int'(a[2:0]), mt));
    check("storeFault", 64'(bus.storeFault), 64'(m_fault));
    check("txValid", 64'(tx_valid), exp_tv);
    check("txData", 64'(tx_data), exp_tx);
    model_update(rst, a, wd, we, mt, rdy);
  endtask

  initial begin
    logic [63:0] a;
    reset = 1'b1; tx_ready = 1'b0;
    bus.addr = '0; bus.writeData = '0; bus.memWrite = 1'b0; bus.memType = 3'd3;
    repeat (2) @(posedge clk);
    m_cyc = '0; m_ovf = 1'b0; m_fault = 1'b0;

    // Reset held, then counter sequence after release
    step(1, MMIO_BASE + 16, 64'h55, 1, 3, 0);
    check("cycle_in_reset", bus.readData, 64'd0);
    step(0, MMIO_BASE + 16, 0, 0, 3, 0); check("cycle0", bus.readData, 64'd0);
    step(0, MMIO_BASE + 16, 0, 0, 3, 0); check("cycle1", bus.readData, 64'd1);
    step(0, MMIO_BASE + 16, 0, 0, 3, 0); check("cycle2", bus.readData, 64'd2);

    // Initialise the RAM words used by random traffic
    for (int w = 0; w < 16; w++) step(0, 64'(w * 8), {$urandom, $urandom}, 1, 3, 0);

    // Load extension on a known doubleword
    step(0, 64'h40, 64'h8877665544332211, 1, 3, 0);
    step(0, 64'h47, 0, 0, 3'd0, 0); check("lb",  bus.readData, 64'hFFFF_FFFF_FFFF_FF88);
    step(0, 64'h47, 0, 0, 3'd4, 0); check("lbu", bus.readData, 64'h88);
    step(0, 64'h42, 0, 0, 3'd1, 0); check("lh",  bus.readData, 64'h4433);
    step(0, 64'h44, 0, 0, 3'd6, 0); check("lwu", bus.readData, 64'h88776655);

    // Misaligned store is dropped and latches the fault
    step(0, 64'h46, 64'hDEADBEEF, 1, 3'd2, 0);
    step(0, 64'h40, 0, 0, 3'd3, 0);
    check("misalign_keep", bus.readData, 64'h8877665544332211);
    check("fault_set", 64'(bus.storeFault), 64'd1);
    step(0, 64'h40, 0, 0, 3'd3, 0);
    check("fault_sticky", 64'(bus.storeFault), 64'd1);

    // Counter load and wrap
    step(0, MMIO_BASE + 16, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3, 0);
    step(0, MMIO_BASE + 16, 0, 0, 3, 0); check("cycle_load", bus.readData, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, MMIO_BASE + 16, 0, 0, 3, 0); check("cycle_wrap", bus.readData, 64'd0);

`ifdef DMEM_CONSOLE_EN
    // Overfill, then drain in order
    for (int i = 0; i < 9; i++) step(0, MMIO_BASE, 64'(8'h41 + i), 1, 3'd0, 0);
    step(0, MMIO_BASE + 8, 0, 0, 3, 0); check("status_full_ovf", bus.readData, 64'h18);
    for (int i = 0; i < 8; i++) begin
      step(0, MMIO_BASE + 8, 0, 0, 3, 1);
      check("tx_seq", 64'(tx_data), 64'(8'h41 + i));
    end
    step(0, MMIO_BASE + 8, 0, 0, 3, 0);
    check("tx_drained", 64'(tx_valid), 64'd0);
    check("status_empty_ovf", bus.readData, 64'h14);
    step(0, MMIO_BASE + 8, 0, 1, 3, 0);
    step(0, MMIO_BASE + 8, 0, 0, 3, 0); check("status_ovf_clr", bus.readData, 64'h04);

    // Push and pop together on a full FIFO
    for (int i = 0; i < 8; i++) step(0, MMIO_BASE, 64'(8'h61 + i), 1, 3'd0, 0);
    step(0, MMIO_BASE, 64'h7A, 1, 3'd0, 1);
    step(0, MMIO_BASE + 8, 0, 0, 3, 0);
    check("status_full_no_ovf", bus.readData, 64'h08);
    check("head_after_pop", 64'(tx_data), 64'h62);
    for (int i = 0; i < 8; i++) step(0, MMIO_BASE + 8, 0, 0, 3, 1);
`else
    step(0, MMIO_BASE, 64'h41, 1, 3'd0, 1);
    step(0, MMIO_BASE + 8, 0, 0, 3, 1);
    check("no_console_valid", 64'(tx_valid), 64'd0);
    check("no_console_status", bus.readData, 64'd0);
`endif

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) < 7)
        a = 64'($urandom_range(0, 127)) + 64'(RAM_BYTES) * 64'($urandom_range(0, 3));
      else
        a = MMIO_BASE + 64'($urandom_range(0, 31));
      step(($urandom_range(0, 63) == 0), a, {$urandom, $urandom},
           ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
